// File: rtl/morse_encoder_if.sv
// Symbol stream and keying interface of the Morse encoder.
//   sym_valid : source offers a symbol on sym
//   sym       : 00 dot, 01 dash, 10 letter gap, 11 word gap
//   sym_ready : encoder can accept a symbol this cycle
//   key       : registered keying output, 1 = tone/mark
//   busy      : encoder has buffered symbols or is sequencing one
// Handshake: a symbol transfers on a rising clk edge where sym_valid and
// sym_ready are both 1; the source holds sym stable while sym_valid=1 and
// sym_ready=0, and sym_ready never depends on sym_valid.
interface morse_encoder_if;
  logic       sym_valid;
  logic [1:0] sym;
  logic       sym_ready;
  logic       key;
  logic       busy;

  modport master (output sym_valid, output sym, input sym_ready, input key, input busy);
  modport slave  (input sym_valid, input sym, output sym_ready, output key, output busy);
endinterface

// File: rtl/morse_encoder.sv
// Morse encoder: buffers dot/dash/gap symbols in a small FIFO and plays them
// out on a keying line, one Morse unit = TIMER_FINAL_VALUE+1 clk cycles.
// Ports:
//   clk     : system clock, all state on rising edge
//   reset   : synchronous active-high reset
//   bus     : morse_encoder_if.slave (sym_valid/sym/sym_ready/key/busy)
//   state_o : debug view of the FSM state (0 IDLE, 1 MARK, 2 SPACE)
module morse_encoder #(
  parameter int TIMER_FINAL_VALUE = 6_999_999,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic            clk,
  input  logic            reset,
  morse_encoder_if.slave  bus,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMER_FINAL_VALUE > 0) ? $clog2(TIMER_FINAL_VALUE + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST    = TW'(TIMER_FINAL_VALUE);
  localparam logic [AW:0]   FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  // ---------------- symbol FIFO ----------------
  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [1:0]    head;

  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign fifo_empty = (count_q == '0);
  // Full is judged on the registered count, so a pop in this cycle does not
  // open the input until the next cycle.
  assign push       = bus.sym_valid & ~fifo_full;
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.sym;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- sequencing FSM ----------------
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    units_q, units_d;   // units remaining after the current one
  logic          key_q;
  logic          tick;
  state_t        ld_state;
  logic [2:0]    ld_units;

  assign tick = (timer_q == TIMER_LAST);

  // What the head symbol loads. Gaps are one unit short of their nominal
  // length because the preceding element already supplied one space unit.
  always_comb begin
    ld_state = MARK;
    ld_units = 3'd0;
    case (head)
      2'b00:   begin ld_state = MARK;  ld_units = 3'd0; end
      2'b01:   begin ld_state = MARK;  ld_units = 3'd2; end
      2'b10:   begin ld_state = SPACE; ld_units = 3'd1; end
      default: begin ld_state = SPACE; ld_units = 3'd5; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    units_d = units_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ld_state;
          units_d = ld_units;
          timer_d = '0;
        end
      end
      MARK: begin
        if (tick) begin
          timer_d = '0;
          if (units_q == 3'd0) begin
            // intra-character gap of one unit
            state_d = SPACE;
            units_d = 3'd0;
          end else begin
            units_d = units_q - 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SPACE: begin
        if (tick) begin
          timer_d = '0;
          if (units_q == 3'd0) begin
            // chain straight into the next symbol, no idle cycle
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = ld_state;
              units_d = ld_units;
            end else begin
              state_d = IDLE;
            end
          end else begin
            units_d = units_q - 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        units_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      units_q <= 3'd0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      units_q <= units_d;
      key_q   <= (state_d == MARK);
    end
  end

  assign bus.sym_ready = ~fifo_full;
  assign bus.key       = key_q;
  assign bus.busy      = (state_q != IDLE) | ~fifo_empty;
  assign state_o       = state_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Testbench for morse_encoder: directed scenarios plus randomized symbol
// streams compared cycle by cycle against a unit-level timing model.
module tb_morse_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  morse_encoder_if bus_a ();
  morse_encoder_if bus_b ();
  logic [1:0] state_a;
  logic [1:0] state_b;

  morse_encoder #(.TIMER_FINAL_VALUE(3), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .state_o(state_a)
  );
  morse_encoder #(.TIMER_FINAL_VALUE(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .state_o(state_b)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  bit   rec_en = 1'b0;
  bit   rec_b  = 1'b0;
  logic obs_key[$];
  logic obs_busy[$];

  always @(negedge clk) begin
    if (rec_en) begin
      if (rec_b) begin
        obs_key.push_back(bus_b.key);
        obs_busy.push_back(bus_b.busy);
      end else begin
        obs_key.push_back(bus_a.key);
        obs_busy.push_back(bus_a.busy);
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [1:0] sym_list[$];
  logic [0:0] exp_key[$];
  logic [0:0] exp_busy[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Morse timing in units: each element is mark units then space units.
  function automatic void build_exp(input int u);
    int n_mark;
    int n_space;
    exp_key.delete();
    exp_busy.delete();
    exp_key.push_back(1'b0);   // cycle of acceptance: buffered, not yet playing
    exp_busy.push_back(1'b1);
    foreach (sym_list[k]) begin
      case (sym_list[k])
        2'd0:    begin n_mark = 1; n_space = 1; end
        2'd1:    begin n_mark = 3; n_space = 1; end
        2'd2:    begin n_mark = 0; n_space = 2; end
        default: begin n_mark = 0; n_space = 6; end
      endcase
      for (int i = 0; i < n_mark * u; i++) begin
        exp_key.push_back(1'b1);
        exp_busy.push_back(1'b1);
      end
      for (int i = 0; i < n_space * u; i++) begin
        exp_key.push_back(1'b0);
        exp_busy.push_back(1'b1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      exp_key.push_back(1'b0);
      exp_busy.push_back(1'b0);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit b, input logic v, input logic [1:0] s);
    if (b) begin
      bus_b.sym_valid = v;
      bus_b.sym       = s;
    end else begin
      bus_a.sym_valid = v;
      bus_a.sym       = s;
    end
  endtask

  // Offer a symbol and hold it until accepted; returns at the accepting edge.
  task automatic push(input bit b, input logic [1:0] s, output int acc_cyc, output int waits);
    logic r;
    r = 1'b0;
    waits = 0;
    #1 drive(b, 1'b1, s);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = b ? bus_b.sym_ready : bus_a.sym_ready;
      @(posedge clk);
      if (r) break;
      waits++;
    end
    acc_cyc = cyc;
    check("push_accepted", r, 1'b1);
  endtask

  task automatic idle(input bit b, input int n);
    #1 drive(b, 1'b0, 2'b00);
    repeat (n) @(posedge clk);
  endtask

  task automatic compare_stream(input string tag, input int u);
    build_exp(u);
    for (int i = 0; i < 5000 && obs_key.size() < exp_key.size(); i++) @(posedge clk);
    rec_en = 1'b0;
    for (int i = 0; i < exp_key.size(); i++) begin
      check($sformatf("%s key[%0d]", tag, i),
            (i < obs_key.size()) ? obs_key[i] : 1'bx, exp_key[i]);
      check($sformatf("%s busy[%0d]", tag, i),
            (i < obs_busy.size()) ? obs_busy[i] : 1'bx, exp_busy[i]);
    end
  endtask

  // Push sym_list back-to-back (optionally with short random pauses that
  // never starve the player) and compare the played waveform.
  task automatic run_stream(input string tag, input bit b, input int u, input bit gaps);
    int acc;
    int w;
    obs_key.delete();
    obs_busy.delete();
    rec_b = b;
    foreach (sym_list[k]) begin
      push(b, sym_list[k], acc, w);
      if (k == 0) rec_en = 1'b1;
      if (gaps && k != sym_list.size() - 1) idle(b, $urandom_range(0, 2));
    end
    idle(b, 0);
    compare_stream(tag, u);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int e0;
    int w;
    int acc[5];
    int wt[5];
    int highs;
    int busies;

    drive(1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 2'b00);

    // Reset with a symbol offered: it must not be stored.
    #1 drive(1'b0, 1'b1, 2'd1);
    drive(1'b1, 1'b1, 2'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst key", bus_a.key, 1'b0);
    check("rst busy", bus_a.busy, 1'b0);
    check("rst ready", bus_a.sym_ready, 1'b1);
    check("rst state", state_a, 2'd0);
    check("rst busy_b", bus_b.busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 2'b00);
    busies = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      busies += int'(bus_a.busy) + int'(bus_b.busy);
    end
    check("rst_no_store busy_cycles", busies, 0);
    @(posedge clk);

    // Single dot, dot+dash back to back, lone word gap.
    sym_list = '{2'd0};
    run_stream("dot", 1'b0, 4, 1'b0);
    sym_list = '{2'd0, 2'd1};
    run_stream("dot_dash", 1'b0, 4, 1'b0);
    sym_list = '{2'd3};
    run_stream("word_gap", 1'b0, 4, 1'b0);

    // Minimum unit: dash, letter gap, dot -> 1,1,1,0,0,0,1,0.
    sym_list = '{2'd1, 2'd2, 2'd0};
    run_stream("min_unit", 1'b1, 1, 1'b0);

    // Backpressure: dash in MARK, then five word gaps offered continuously.
    obs_key.delete();
    obs_busy.delete();
    rec_b = 1'b0;
    push(1'b0, 2'd1, e0, w);
    rec_en = 1'b1;
    idle(1'b0, 1);
    for (int i = 0; i < 5; i++) push(1'b0, 2'd3, acc[i], wt[i]);
    idle(1'b0, 0);
    for (int i = 0; i < 4; i++) check($sformatf("bp acc_cycle%0d", i), acc[i] - e0, 2 + i);
    check("bp held_cycles", wt[4], 12);
    check("bp fifth_accept", acc[4] - e0, 18);
    sym_list = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    compare_stream("backpressure", 4);

    // Reset in the middle of a dash with two dots buffered.
    push(1'b0, 2'd1, e0, w);
    push(1'b0, 2'd0, acc[0], w);
    push(1'b0, 2'd0, acc[1], w);
    idle(1'b0, 4);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_dash key_before", bus_a.key, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_dash key", bus_a.key, 1'b0);
    check("mid_dash busy", bus_a.busy, 1'b0);
    check("mid_dash ready", bus_a.sym_ready, 1'b1);
    check("mid_dash state", state_a, 2'd0);
    highs = 0;
    busies = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      highs += int'(bus_a.key);
      busies += int'(bus_a.busy);
    end
    check("mid_dash flushed key_cycles", highs, 0);
    check("mid_dash flushed busy_cycles", busies, 0);
    @(posedge clk);

    // Random streams.
    for (int t = 0; t < 6; t++) begin
      sym_list.delete();
      for (int k = 0; k < $urandom_range(1, 6); k++) sym_list.push_back(2'($urandom_range(0, 3)));
      run_stream($sformatf("rand_a%0d", t), 1'b0, 4, 1'b1);
    end
    for (int t = 0; t < 4; t++) begin
      sym_list.delete();
      for (int k = 0; k < $urandom_range(1, 8); k++) sym_list.push_back(2'($urandom_range(0, 3)));
      run_stream($sformatf("rand_b%0d", t), 1'b1, 1, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
